// File: rtl/grid_state_sequencer.sv
// Host-side sequencer for the agent grid: loads an init image, lets the grid evolve
// for a programmed number of steps, then streams back a snapshot and its popcount.
module grid_state_sequencer #(
  parameter int X     = 2,
  parameter int Y     = 2,
  parameter int W     = 8,
  parameter int STEPW = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [STEPW-1:0]             num_steps,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [W-1:0]                 cfg_data,
  output logic [X*Y-1:0]               init_state,
  output logic                         load_state,
  input  logic [X*Y-1:0]               states,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic                         out_last,
  output logic [$clog2(X*Y+1)-1:0]     infected_count,
  output logic                         busy,
  output logic                         done
);

  localparam int N  = X * Y;
  localparam int NW = (N + W - 1) / W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  // Both streams use strict valid/ready: a word moves on a cycle where valid and
  // ready are both high; valid never depends on ready, and data holds while stalled.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_RUN,
    S_SNAP,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STEPW-1:0]  steps_q, steps_d;
  logic [N-1:0]      img_q, img_d;
  logic [N-1:0]      snap_q, snap_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NW*W-1:0]   snap_pad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      steps_q <= '0;
      img_q   <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      img_q   <= img_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    steps_d    = steps_q;
    img_d      = img_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    cfg_ready  = 1'b0;
    load_state = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          steps_d = num_steps;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          for (int b = 0; b < N; b++) begin
            if ((b / W) == int'(idx_q)) img_d[b] = cfg_data[b % W];
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_STROBE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_STROBE: begin
        load_state = 1'b1;
        state_d    = (steps_q == '0) ? S_SNAP : S_RUN;
      end
      S_RUN: begin
        // Down-counter: a run of num_steps spends exactly num_steps cycles here,
        // so the grid clocks num_steps updates between load and capture.
        if (steps_q <= STEPW'(1)) begin
          state_d = S_SNAP;
        end else begin
          steps_d = steps_q - STEPW'(1);
        end
      end
      S_SNAP: begin
        snap_d = states;
        cnt_d  = '0;
        for (int b = 0; b < N; b++) begin
          cnt_d = cnt_d + CW'(states[b]);
        end
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bits beyond the last agent read as zero in the final output word.
  always_comb begin
    snap_pad        = '0;
    snap_pad[N-1:0] = snap_q;
  end

  always_comb begin
    out_data = '0;
    if (state_q == S_SEND) begin
      for (int k = 0; k < NW; k++) begin
        if (k == int'(idx_q)) out_data = snap_pad[k*W +: W];
      end
    end
  end

  assign out_last       = (state_q == S_SEND) && (idx_q == LAST_IDX);
  assign busy           = (state_q != S_IDLE);
  assign init_state     = img_q;
  assign infected_count = cnt_q;

endmodule

// File: tb/tb_grid_state_sequencer.sv
// Directed bench: a 2x2 instance driven from a vector table plus corner sequences,
// and a 4x4 instance for the two-word image and output backpressure.
module tb_grid_state_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2x2 instance
  logic        start_a, cfg_valid_a, cfg_ready_a, load_a, out_valid_a, out_ready_a;
  logic        out_last_a, busy_a, done_a;
  logic [15:0] nsteps_a;
  logic [7:0]  cfg_data_a, out_data_a;
  logic [3:0]  init_a, states_a, fixed_a, grid_a;
  logic [2:0]  cnt_a;
  logic        toggle_en;

  // 4x4 instance
  logic        start_b, cfg_valid_b, cfg_ready_b, load_b, out_valid_b, out_ready_b;
  logic        out_last_b, busy_b, done_b;
  logic [15:0] nsteps_b, init_b, states_b;
  logic [7:0]  cfg_data_b, out_data_b;
  logic [4:0]  cnt_b;

  grid_state_sequencer #(.X(2), .Y(2), .W(8), .STEPW(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .num_steps(nsteps_a),
    .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a), .cfg_data(cfg_data_a),
    .init_state(init_a), .load_state(load_a), .states(states_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .infected_count(cnt_a), .busy(busy_a), .done(done_a)
  );

  grid_state_sequencer #(.X(4), .Y(4), .W(8), .STEPW(16)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .num_steps(nsteps_b),
    .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_data(cfg_data_b),
    .init_state(init_b), .load_state(load_b), .states(states_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .infected_count(cnt_b), .busy(busy_b), .done(done_b)
  );

  // Toy grid: takes the image on load, otherwise inverts every cycle.
  always @(posedge clk) begin
    if (load_a) grid_a <= init_a;
    else        grid_a <= ~grid_a;
  end
  assign states_a = toggle_en ? grid_a : fixed_a;

  int total = 0;
  int bad   = 0;
  int loads_a = 0, dones_a = 0, loads_b = 0, dones_b = 0;
  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters and output scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_a) loads_a++;
    if (done_a) dones_a++;
    if (load_b) loads_b++;
    if (done_b) dones_b++;
    if (out_valid_a && out_ready_a) begin
      if (exp_qa.size() == 0) check("sb_a_unexpected", 1, 0);
      else check("sb_a_word", out_data_a, exp_qa.pop_front());
    end
    if (out_valid_b && out_ready_b) begin
      if (exp_qb.size() == 0) check("sb_b_unexpected", 1, 0);
      else check("sb_b_word", out_data_b, exp_qb.pop_front());
    end
  end

  typedef struct {
    logic [15:0] steps;
    logic [7:0]  cfg;
    logic [3:0]  st;
    logic [3:0]  exp_init;
    logic [7:0]  exp_word;
    logic [2:0]  exp_cnt;
    bit          extra_start;
    bit          toggle;
  } vec_t;

  vec_t vecs[6];

  // Start, load one word, leave the DUT in STROBE.
  task automatic start_load_a(input logic [15:0] steps, input logic [7:0] cfg);
    start_a  = 1'b1;
    nsteps_a = steps;
    tick();
    start_a  = 1'b0;
    nsteps_a = 16'hFFFF;
    cfg_valid_a = 1'b1;
    cfg_data_a  = cfg;
    tick();
    cfg_valid_a = 1'b0;
    cfg_data_a  = 8'h00;
  endtask

  task automatic run_a(input vec_t v, input string tag);
    int l0, d0, cyc;
    fixed_a     = v.st;
    toggle_en   = v.toggle;
    out_ready_a = 1'b1;
    l0 = loads_a;
    d0 = dones_a;
    start_a  = 1'b1;
    nsteps_a = v.steps;
    tick();
    start_a  = 1'b0;
    nsteps_a = 16'hFFFF;
    check({tag, "_cfg_ready"}, cfg_ready_a, 1);
    cfg_valid_a = 1'b1;
    cfg_data_a  = v.cfg;
    tick();
    cfg_valid_a = 1'b0;
    cfg_data_a  = 8'h00;
    check({tag, "_load"}, load_a, 1);
    check({tag, "_init"}, init_a, v.exp_init);
    exp_qa.push_back(v.exp_word);
    cyc = 0;
    while (!out_valid_a && cyc < int'(v.steps) + 20) begin
      tick();
      cyc++;
      start_a = v.extra_start && (cyc == 1);
    end
    start_a = 1'b0;
    check({tag, "_latency"}, cyc, int'(v.steps) + 2);
    check({tag, "_out_data"}, out_data_a, v.exp_word);
    check({tag, "_out_last"}, out_last_a, 1);
    check({tag, "_count"}, cnt_a, v.exp_cnt);
    check({tag, "_done"}, done_a, 1);
    tick();
    check({tag, "_idle"}, {busy_a, out_valid_a, done_a}, 0);
    check({tag, "_count_hold"}, cnt_a, v.exp_cnt);
    check({tag, "_init_hold"}, init_a, v.exp_init);
    check({tag, "_loads"}, loads_a - l0, 1);
    check({tag, "_dones"}, dones_a - d0, 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_load"}, load_a, 0);
    check({tag, "_cfg_ready"}, cfg_ready_a, 0);
    check({tag, "_out"}, {out_valid_a, out_last_a, done_a, out_data_a}, 0);
    check({tag, "_init"}, init_a, 0);
    check({tag, "_count"}, cnt_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, l0, cyc;
    vecs[0] = '{16'd0,   8'hF5, 4'b0101, 4'h5, 8'h05, 3'd2, 1'b0, 1'b0};
    vecs[1] = '{16'd1,   8'h0A, 4'b1111, 4'hA, 8'h0F, 3'd4, 1'b0, 1'b0};
    vecs[2] = '{16'd2,   8'h33, 4'b0000, 4'h3, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{16'd5,   8'hFF, 4'b1000, 4'hF, 8'h08, 3'd1, 1'b1, 1'b0};
    vecs[4] = '{16'd4,   8'h03, 4'b0000, 4'h3, 8'h03, 3'd2, 1'b0, 1'b1};
    vecs[5] = '{16'd300, 8'h96, 4'b0110, 4'h6, 8'h06, 3'd2, 1'b0, 1'b0};

    start_a = 0; nsteps_a = 0; cfg_valid_a = 0; cfg_data_a = 0; out_ready_a = 0;
    fixed_a = 0; toggle_en = 0;
    start_b = 0; nsteps_b = 0; cfg_valid_b = 0; cfg_data_b = 0; out_ready_b = 0;
    states_b = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("rst0_a");
    check("rst0_b", {busy_b, cfg_ready_b, load_b, out_valid_b, cnt_b, init_b}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // cfg_valid in IDLE must be ignored.
    l0 = loads_a;
    cfg_valid_a = 1'b1;
    cfg_data_a  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      check("idle_cfg_ready", cfg_ready_a, 0);
      check("idle_busy", busy_a, 0);
      tick();
    end
    cfg_valid_a = 1'b0;
    check("idle_init_kept", init_a, 4'h6);
    check("idle_no_load", loads_a - l0, 0);

    // Reset in the middle of RUN.
    d0 = dones_a;
    fixed_a = 4'b1111;
    toggle_en = 1'b0;
    start_load_a(16'd50, 8'h09);
    repeat (3) tick();
    check("mid_run_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_a("rst_run");
    rst = 1'b0;
    tick();
    check("rst_run_no_done", dones_a - d0, 0);
    run_a(vecs[1], "after_rst");
    tick();

    // Reset while the load strobe is high drops it immediately.
    start_load_a(16'd7, 8'h0C);
    check("strobe_load_hi", load_a, 1);
    #2 rst = 1'b1;
    #1;
    check("strobe_load_lo", load_a, 0);
    rst = 1'b0;
    tick();

    // 4x4: two-word image with a cfg stall, then output backpressure.
    states_b = 16'h8012;
    start_b  = 1'b1;
    nsteps_b = 16'd3;
    tick();
    start_b = 1'b0;
    cfg_valid_b = 1'b1;
    cfg_data_b  = 8'h12;
    tick();
    cfg_valid_b = 1'b0;
    tick();
    check("b_stall_ready", cfg_ready_b, 1);
    check("b_stall_noload", load_b, 0);
    cfg_valid_b = 1'b1;
    cfg_data_b  = 8'h80;
    tick();
    cfg_valid_b = 1'b0;
    check("b_load", load_b, 1);
    check("b_init", init_b, 16'h8012);
    exp_qb.push_back(8'h12);
    exp_qb.push_back(8'h80);
    cyc = 0;
    while (!out_valid_b && cyc < 50) begin
      tick();
      cyc++;
    end
    check("b_latency", cyc, 5);
    for (int i = 0; i < 5; i++) begin
      check("b_bp_valid", out_valid_b, 1);
      check("b_bp_word", {out_last_b, out_data_b}, {1'b0, 8'h12});
      check("b_bp_done", done_b, 0);
      tick();
    end
    out_ready_b = 1'b1;
    check("b_w0_done", done_b, 0);
    tick();
    check("b_w1_word", {out_last_b, out_data_b}, {1'b1, 8'h80});
    check("b_w1_done", done_b, 1);
    check("b_count", cnt_b, 3);
    tick();
    check("b_idle", busy_b, 0);
    check("b_dones", dones_b, 1);
    check("b_loads", loads_b, 1);

    check("sb_a_drained", exp_qa.size(), 0);
    check("sb_b_drained", exp_qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_state_sequencer.md
Name: grid_state_sequencer

Overview:
- Host-side counterpart to the agent grid network.
- Accepts an initial infection image as W-bit words on a valid/ready stream and drives the grid's init_state/load_state pair.
- Lets the grid evolve for a programmed number of clock steps, then snapshots the grid's states vector.
- Returns the snapshot as W-bit words on a valid/ready stream, together with a population count of infected agents.

Parameters:
- X, 2, grid columns
- Y, 2, grid rows
- W, 8, stream word width; NW = ceil(X*Y/W) words per image
- STEPW, 16, width of step counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a run (sampled only in IDLE)
- num_steps  in  STEPW  evolution steps for this run (sampled with start)
- cfg_valid  in  1  init-image word valid
- cfg_ready  out  1  init-image word accepted
- cfg_data  in  W  init-image word
- init_state  out  X*Y  image to grid initState bus
- load_state  out  1  one-cycle load strobe to grid
- states  in  X*Y  grid currState vector
- out_valid  out  1  snapshot word valid
- out_ready  in  1  downstream accepts word
- out_data  out  W  snapshot word
- out_last  out  1  marks word NW-1
- infected_count  out  clog2(X*Y+1)  popcount of last snapshot
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when last word transfers

Behaviour:
- Reset, asynchronous: FSM=IDLE. All outputs 0: init_state, load_state, cfg_ready, out_valid, out_data, out_last, infected_count, busy, done. Word and step counters cleared.
- Word packing: word k carries image bits [k*W +: W], bit 0 = agent 0. In the last cfg word, bits at index >= X*Y are ignored. In the last out word, those bits are driven 0.
- IDLE:
  - start=1 → LOAD; latch num_steps; word index=0.
  - cfg_valid is ignored.
- LOAD:
  - cfg_ready=1.
  - On each cfg_valid&cfg_ready, the word is written into the init_state slice k, k++.
  - After word NW-1 is accepted → STROBE.
  - init_state bits update the cycle after acceptance.
- STROBE:
  - load_state=1 for exactly one cycle; cfg_ready=0.
  - Next: if latched steps==0 → SNAP, else → RUN with step counter=steps.
- RUN:
  - Decrement the step counter each cycle; when it reaches 1 → SNAP.
  - Effective timing: the grid sees exactly num_steps update edges after the load edge before capture.
- SNAP:
  - One cycle. Register states into the snapshot register.
  - Register infected_count = popcount(states).
  - → SEND, word index=0.
- SEND:
  - out_valid=1; out_data = snapshot slice k; out_last=(k==NW-1).
  - On out_valid&out_ready: k++; on the last word → IDLE with done=1 for that one cycle.
  - While out_valid&!out_ready, out_data and out_last stay stable.
- infected_count holds its value until the next SNAP or reset.
- init_state holds after STROBE; it is overwritten only by the next LOAD.
- busy=1 in LOAD, STROBE, RUN, SNAP, SEND.
- start is ignored while busy.
- num_steps at its maximum (2^STEPW-1) must not wrap; the counter is a down-counter.
- Reset mid-run (any state) returns to IDLE immediately: no partial stream completion, no done pulse, load_state deasserts asynchronously.
- A cfg stall (cfg_valid low) in LOAD waits indefinitely. out_ready low in SEND waits indefinitely.
- Latency, start to first out_valid, with no stalls: NW (LOAD) + 1 (STROBE) + num_steps (RUN) + 1 (SNAP) cycles.

Test Plan:
- X=Y=2, W=8; start, num_steps=0, cfg word 0xF5, states tied to 4'b0101 → load_state pulses once; init_state=4'b0101; out_data=0x05, out_last=1; infected_count=2; done pulses once.
- X=Y=4, W=8, num_steps=3; cfg words 0x12 then 0x80, states driven 16'h8012 → init_state=16'h8012; out words 0x12 then 0x80; out_last only on word 1; infected_count=3.
- Backpressure: hold out_ready=0 for 5 cycles in SEND → out_valid stays 1; out_data and out_last remain stable; no done until out_ready=1.
- num_steps=4 with a cycle counter → exactly 4 RUN cycles between the load_state pulse and the SNAP capture; a grid toggling states each cycle yields the 4th-edge value.
- Assert rst during RUN → all outputs 0 within the same cycle; busy=0; a subsequent start runs normally.
- Pulse start while busy, and drive cfg_valid in IDLE → both ignored; cfg_ready stays 0; no extra load_state pulse.
